mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
Multicycle control FSM for the CPU datapath.
- Sequences each instruction through IF/ID/EXE/MEM/WB.
- Decodes the IR opcode into datapath controls.
- Drives RegDst, the 2-bit select of the write-register-address mux feeding the register file.
- Outputs are combinational decode of the current state register plus the `op` input; `op` comes from IR and is stable from ID onward.

Parameters:
HALT_OP, 6'b111111, opcode that parks the FSM in sHALT

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous active-low reset
op  in  6  IR[31:26]
zero  in  1  ALU zero flag, valid in EXE
PCWre  out  1  PC load enable
IRWre  out  1  IR load enable
InsMemRW  out  1  instruction memory read
ALUSrcA  out  1  0=rs data, 1=shamt
ALUSrcB  out  1  0=rt data, 1=extended imm
ExtSel  out  1  0=zero-extend, 1=sign-extend
ALUOp  out  3  000 add, 001 sub, 010 B<<A, 011 or, 100 and, 101 sltu, 110 slt
mRD  out  1  data memory read
mWR  out  1  data memory write
DBDataSrc  out  1  0=ALU result, 1=memory data
RegWre  out  1  register file write enable
WrRegDSrc  out  1  0=PC+4, 1=DB
RegDst  out  2  0=$31, 1=rt, 2=rd; 3 never driven
PCSrc  out  2  0=PC+4, 1=branch target, 2=rs (jr), 3=jump address
state_o  out  4  current state, for debug

Behaviour:
- Opcodes:
  - add 000000, sub 000001, addi 000010
  - or 010000, and 010001, ori 010010
  - sll 011000, slt 100110, sltiu 100111
  - sw 110000, lw 110001, beq 110100
  - j 111000, jr 111001, jal 111010, halt = HALT_OP
- States: sIF 0000, sID 0001, sEXE_AL 0110, sWB_AL 0111, sEXE_BR 0101, sEXE_LS 0010, sMEM 0011, sWB_LD 0100, sHALT 1111.
- Reset: RST low at an edge forces sIF. Any state is valid for reset, including mid-instruction.
- Output values in sIF (these are the reset values): IRWre=1, InsMemRW=1; all other enables 0; ALUOp=000, RegDst=00, PCSrc=00.
- Outputs not listed for a state are 0.
- Transitions and outputs per state:
  - sIF -> sID unconditionally. IRWre=1, InsMemRW=1.
  - sID, opcode j: PCWre=1, PCSrc=3 -> sIF.
  - sID, opcode jr: PCWre=1, PCSrc=2 -> sIF.
  - sID, opcode jal: PCWre=1, PCSrc=3, RegWre=1, RegDst=0, WrRegDSrc=0 -> sIF.
  - sID, other opcodes: beq -> sEXE_BR; lw/sw -> sEXE_LS; halt -> sHALT; remaining ALU ops -> sEXE_AL.
  - sID, undefined opcode: PCWre=1, PCSrc=0 -> sIF (executes as nop).
- sEXE_AL:
  - ALUOp per opcode.
  - ALUSrcA=1 for sll.
  - ALUSrcB=1 for addi/ori/sltiu.
  - ExtSel=0 for ori/sltiu, else 1.
  - -> sWB_AL.
- sWB_AL:
  - RegWre=1, WrRegDSrc=1, DBDataSrc=0, PCWre=1, PCSrc=0.
  - RegDst=1 for addi/ori/sltiu, RegDst=2 for R-type.
  - ALU controls held as in sEXE_AL.
  - -> sIF.
- sEXE_BR: ALUOp=001, ExtSel=1, PCWre=1, PCSrc = zero ? 1 : 0 -> sIF.
- sEXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1 -> sMEM.
- sMEM, sw: mWR=1, PCWre=1, PCSrc=0 -> sIF.
- sMEM, lw: mRD=1 -> sWB_LD.
- sWB_LD: mRD=1, DBDataSrc=1, RegWre=1, WrRegDSrc=1, RegDst=1, PCWre=1, PCSrc=0 -> sIF.
- sHALT: all enables 0; stays until RST low.
- Invariants:
  - PCWre is high exactly once per instruction, in its last state.
  - RegWre and mWR are never high together.
  - RegDst=3 is never output.
- Latency in cycles: j/jr/jal 2; beq 3; sw 4; ALU ops 4; lw 5.
- A single state_o change per clock; no combinational path from zero to state.

Test Plan:
1. RST low 2 cycles, then high: state_o=0000, IRWre=1, PCWre=0; next edge state_o=0001.
2. op=000000 (add): states 0000,0001,0110,0111,0000. In 0111: RegWre=1, RegDst=2, PCWre=1, ALUOp=000.
3. op=110001 (lw): states 0000,0001,0010,0011,0100,0000. In 0100: DBDataSrc=1, RegDst=1, RegWre=1. op=110000 (sw): mWR=1 in 0011, then 0000; RegWre stays 0.
4. op=110100 (beq) with zero=1: PCSrc=1 in 0101. Repeat with zero=0: PCSrc=0. Both return to 0000 after 3 cycles.
5. op=111010 (jal): in 0001 RegWre=1, RegDst=0, WrRegDSrc=0, PCSrc=3; next state 0000. op=111001 (jr): PCSrc=2, RegWre=0.
6. op=111111: reaches 1111 and stays 20 cycles with all enables 0. RST low in 1111 -> 0000. Reset asserted during lw state 0011 -> 0000 next edge; mRD drops to 0.

Source files
------------

// File: rtl/mc_control_unit_if.sv
// rtl/mc_control_unit_if.sv - control-unit <-> datapath signal bundle
//
// Purpose: groups the opcode/flag inputs and all datapath control outputs
//          of the multicycle control unit into one bundle.
// Modports:
//   master - control unit side: samples op/zero, drives every control line
//   slave  - datapath side: drives op/zero, samples every control line
// Signals:
//   op[5:0]   IR[31:26]               zero       ALU zero flag
//   PCWre     PC load enable          IRWre      IR load enable
//   InsMemRW  instruction mem read    ALUSrcA    0=rs, 1=shamt
//   ALUSrcB   0=rt, 1=extended imm    ExtSel     0=zero-ext, 1=sign-ext
//   ALUOp[2:0] ALU function           mRD/mWR    data memory read/write
//   DBDataSrc 0=ALU, 1=memory         RegWre     register file write enable
//   WrRegDSrc 0=PC+4, 1=DB            RegDst[1:0] 0=$31, 1=rt, 2=rd
//   PCSrc[1:0] 0=PC+4, 1=branch, 2=rs, 3=jump   state_o[3:0] current state
interface mc_control_unit_if;
    logic [5:0] op;
    logic       zero;
    logic       PCWre;
    logic       IRWre;
    logic       InsMemRW;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic       ExtSel;
    logic [2:0] ALUOp;
    logic       mRD;
    logic       mWR;
    logic       DBDataSrc;
    logic       RegWre;
    logic       WrRegDSrc;
    logic [1:0] RegDst;
    logic [1:0] PCSrc;
    logic [3:0] state_o;

    modport master (
        input  op, zero,
        output PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, ALUOp,
               mRD, mWR, DBDataSrc, RegWre, WrRegDSrc, RegDst, PCSrc, state_o
    );

    modport slave (
        output op, zero,
        input  PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, ALUOp,
               mRD, mWR, DBDataSrc, RegWre, WrRegDSrc, RegDst, PCSrc, state_o
    );
endinterface

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle CPU control FSM (IF/ID/EXE/MEM/WB)
//
// Purpose: sequences each instruction through its states and decodes the
//          opcode into datapath controls. Outputs are a combinational
//          decode of the state register and op (op is stable from ID on).
// Ports:
//   CLK  - clock, all state updates on the rising edge
//   RST  - synchronous active-low reset, forces sIF from any state
//   bus  - mc_control_unit_if.master: op/zero in, datapath controls out
// Parameters:
//   HALT_OP - opcode that parks the FSM in sHALT until reset
module mc_control_unit #(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic              CLK,
    input  logic              RST,
    mc_control_unit_if.master bus
);

    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_LD  = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1111
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SLTIU = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;

    state_t r_state;
    state_t w_next_state;

    logic       w_is_rtype;
    logic       w_is_itype;
    logic [2:0] w_alu_op;

    // Register-destination ALU ops write rd, immediate ALU ops write rt.
    assign w_is_rtype = (bus.op == OP_ADD) || (bus.op == OP_SUB) ||
                        (bus.op == OP_OR)  || (bus.op == OP_AND) ||
                        (bus.op == OP_SLL) || (bus.op == OP_SLT);
    assign w_is_itype = (bus.op == OP_ADDI) || (bus.op == OP_ORI) ||
                        (bus.op == OP_SLTIU);

    always_comb begin
        w_alu_op = 3'b000;
        case (bus.op)
            OP_SUB:          w_alu_op = 3'b001;
            OP_SLL:          w_alu_op = 3'b010;
            OP_OR, OP_ORI:   w_alu_op = 3'b011;
            OP_AND:          w_alu_op = 3'b100;
            OP_SLTIU:        w_alu_op = 3'b101;
            OP_SLT:          w_alu_op = 3'b110;
            default:         w_alu_op = 3'b000;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) r_state <= S_IF;
        else      r_state <= w_next_state;
    end

    assign bus.state_o = r_state;

    always_comb begin
        w_next_state  = S_IF;
        bus.PCWre     = 1'b0;
        bus.IRWre     = 1'b0;
        bus.InsMemRW  = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 1'b0;
        bus.ExtSel    = 1'b0;
        bus.ALUOp     = 3'b000;
        bus.mRD       = 1'b0;
        bus.mWR       = 1'b0;
        bus.DBDataSrc = 1'b0;
        bus.RegWre    = 1'b0;
        bus.WrRegDSrc = 1'b0;
        bus.RegDst    = 2'd0;
        bus.PCSrc     = 2'd0;

        case (r_state)
            S_IF: begin
                bus.IRWre    = 1'b1;
                bus.InsMemRW = 1'b1;
                w_next_state = S_ID;
            end

            S_ID: begin
                if (bus.op == OP_J) begin
                    bus.PCWre    = 1'b1;
                    bus.PCSrc    = 2'd3;
                    w_next_state = S_IF;
                end else if (bus.op == OP_JR) begin
                    bus.PCWre    = 1'b1;
                    bus.PCSrc    = 2'd2;
                    w_next_state = S_IF;
                end else if (bus.op == OP_JAL) begin
                    // Link: write PC+4 into $31 while jumping.
                    bus.PCWre     = 1'b1;
                    bus.PCSrc     = 2'd3;
                    bus.RegWre    = 1'b1;
                    bus.RegDst    = 2'd0;
                    bus.WrRegDSrc = 1'b0;
                    w_next_state  = S_IF;
                end else if (bus.op == OP_BEQ) begin
                    w_next_state = S_EXE_BR;
                end else if ((bus.op == OP_LW) || (bus.op == OP_SW)) begin
                    w_next_state = S_EXE_LS;
                end else if (bus.op == HALT_OP) begin
                    w_next_state = S_HALT;
                end else if (w_is_rtype || w_is_itype) begin
                    w_next_state = S_EXE_AL;
                end else begin
                    // Unknown opcode retires as a nop.
                    bus.PCWre    = 1'b1;
                    bus.PCSrc    = 2'd0;
                    w_next_state = S_IF;
                end
            end

            S_EXE_AL, S_WB_AL: begin
                // ALU controls stay asserted through WB so the result on DB
                // remains valid while the register file captures it.
                bus.ALUOp   = w_alu_op;
                bus.ALUSrcA = (bus.op == OP_SLL);
                bus.ALUSrcB = w_is_itype;
                bus.ExtSel  = !((bus.op == OP_ORI) || (bus.op == OP_SLTIU));
                if (r_state == S_WB_AL) begin
                    bus.RegWre    = 1'b1;
                    bus.WrRegDSrc = 1'b1;
                    bus.DBDataSrc = 1'b0;
                    bus.PCWre     = 1'b1;
                    bus.PCSrc     = 2'd0;
                    bus.RegDst    = w_is_itype ? 2'd1 : 2'd2;
                    w_next_state  = S_IF;
                end else begin
                    w_next_state  = S_WB_AL;
                end
            end

            S_EXE_BR: begin
                bus.ALUOp    = 3'b001;
                bus.ExtSel   = 1'b1;
                bus.PCWre    = 1'b1;
                bus.PCSrc    = bus.zero ? 2'd1 : 2'd0;
                w_next_state = S_IF;
            end

            S_EXE_LS: begin
                bus.ALUOp    = 3'b000;
                bus.ALUSrcB  = 1'b1;
                bus.ExtSel   = 1'b1;
                w_next_state = S_MEM;
            end

            S_MEM: begin
                // Only lw/sw reach this state.
                if (bus.op == OP_SW) begin
                    bus.mWR      = 1'b1;
                    bus.PCWre    = 1'b1;
                    bus.PCSrc    = 2'd0;
                    w_next_state = S_IF;
                end else begin
                    bus.mRD      = 1'b1;
                    w_next_state = S_WB_LD;
                end
            end

            S_WB_LD: begin
                bus.mRD       = 1'b1;
                bus.DBDataSrc = 1'b1;
                bus.RegWre    = 1'b1;
                bus.WrRegDSrc = 1'b1;
                bus.RegDst    = 2'd1;
                bus.PCWre     = 1'b1;
                bus.PCSrc     = 2'd0;
                w_next_state  = S_IF;
            end

            S_HALT: begin
                w_next_state = S_HALT;
            end

            default: begin
                w_next_state = S_IF;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - directed self-checking bench for mc_control_unit
module tb_mc_control_unit;

    logic CLK = 1'b0;
    logic RST;
    int   n_tests = 0;
    int   n_fail  = 0;

    mc_control_unit_if bus();

    mc_control_unit #(.HALT_OP(6'b111111)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic test_reset();
        RST = 1'b0; bus.op = 6'b000000; bus.zero = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        if (bus.state_o !== 4'b0000) begin $display("FAIL reset_state got=%b exp=0000", bus.state_o); n_fail++; end
        n_tests++;
        if (bus.IRWre !== 1'b1 || bus.InsMemRW !== 1'b1) begin $display("FAIL reset_fetch got IRWre=%b InsMemRW=%b exp=1,1", bus.IRWre, bus.InsMemRW); n_fail++; end
        n_tests++;
        if (bus.PCWre !== 1'b0 || bus.RegWre !== 1'b0 || bus.mWR !== 1'b0 || bus.mRD !== 1'b0 ||
            bus.ALUOp !== 3'b000 || bus.RegDst !== 2'd0 || bus.PCSrc !== 2'd0) begin
            $display("FAIL reset_outputs got PCWre=%b RegWre=%b mWR=%b mRD=%b ALUOp=%b RegDst=%0d PCSrc=%0d exp all 0",
                     bus.PCWre, bus.RegWre, bus.mWR, bus.mRD, bus.ALUOp, bus.RegDst, bus.PCSrc);
            n_fail++;
        end
        n_tests++;
        @(negedge CLK);
        if (bus.state_o !== 4'b0001) begin $display("FAIL reset_to_id got=%b exp=0001", bus.state_o); n_fail++; end
        n_tests++;
        repeat (3) @(negedge CLK);
        if (bus.state_o !== 4'b0000) begin $display("FAIL reset_add_return got=%b exp=0000", bus.state_o); n_fail++; end
        n_tests++;
    endtask

    // Each ALU op: opcode, ALUOp, ALUSrcA, ALUSrcB, ExtSel, RegDst in WB.
    task automatic test_alu_ops();
        logic [5:0] t_op  [9] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                                  6'b010010, 6'b011000, 6'b100110, 6'b100111};
        logic [2:0] t_alu [9] = '{3'b000, 3'b001, 3'b000, 3'b011, 3'b100,
                                  3'b011, 3'b010, 3'b110, 3'b101};
        logic       t_sa  [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        logic       t_sb  [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
        logic       t_ext [9] = '{1, 1, 1, 1, 1, 0, 1, 1, 0};
        logic [1:0] t_dst [9] = '{2, 2, 1, 2, 2, 1, 2, 2, 1};
        logic [3:0] seq   [4] = '{4'b0000, 4'b0001, 4'b0110, 4'b0111};
        for (int k = 0; k < 9; k++) begin
            bus.op = t_op[k];
            for (int i = 0; i < 4; i++) begin
                if (bus.state_o !== seq[i]) begin $display("FAIL alu_state op=%b step=%0d got=%b exp=%b", t_op[k], i, bus.state_o, seq[i]); n_fail++; end
                n_tests++;
                if (bus.PCWre !== (i == 3)) begin $display("FAIL alu_pcwre op=%b step=%0d got=%b exp=%b", t_op[k], i, bus.PCWre, (i == 3)); n_fail++; end
                n_tests++;
                if (i >= 2) begin
                    if (bus.ALUOp !== t_alu[k] || bus.ALUSrcA !== t_sa[k] || bus.ALUSrcB !== t_sb[k] || bus.ExtSel !== t_ext[k]) begin
                        $display("FAIL alu_ctrl op=%b step=%0d got ALUOp=%b A=%b B=%b Ext=%b exp ALUOp=%b A=%b B=%b Ext=%b",
                                 t_op[k], i, bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.ExtSel, t_alu[k], t_sa[k], t_sb[k], t_ext[k]);
                        n_fail++;
                    end
                    n_tests++;
                end
                if (i == 3) begin
                    if (bus.RegWre !== 1'b1 || bus.RegDst !== t_dst[k] || bus.WrRegDSrc !== 1'b1 ||
                        bus.DBDataSrc !== 1'b0 || bus.PCSrc !== 2'd0) begin
                        $display("FAIL alu_wb op=%b got RegWre=%b RegDst=%0d WrRegDSrc=%b DBDataSrc=%b PCSrc=%0d exp 1,%0d,1,0,0",
                                 t_op[k], bus.RegWre, bus.RegDst, bus.WrRegDSrc, bus.DBDataSrc, bus.PCSrc, t_dst[k]);
                        n_fail++;
                    end
                    n_tests++;
                end
                @(negedge CLK);
            end
            if (bus.state_o !== 4'b0000) begin $display("FAIL alu_return op=%b got=%b exp=0000", t_op[k], bus.state_o); n_fail++; end
            n_tests++;
        end
    endtask

    task automatic test_load_store();
        logic [3:0] seq_lw [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100};
        logic [3:0] seq_sw [4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011};
        bus.op = 6'b110001;
        for (int i = 0; i < 5; i++) begin
            if (bus.state_o !== seq_lw[i]) begin $display("FAIL lw_state step=%0d got=%b exp=%b", i, bus.state_o, seq_lw[i]); n_fail++; end
            n_tests++;
            if (bus.PCWre !== (i == 4)) begin $display("FAIL lw_pcwre step=%0d got=%b exp=%b", i, bus.PCWre, (i == 4)); n_fail++; end
            n_tests++;
            if (i == 2 && (bus.ALUSrcB !== 1'b1 || bus.ExtSel !== 1'b1 || bus.ALUOp !== 3'b000)) begin
                $display("FAIL lw_exe got ALUSrcB=%b ExtSel=%b ALUOp=%b exp 1,1,000", bus.ALUSrcB, bus.ExtSel, bus.ALUOp); n_fail++;
            end
            if (i == 2) n_tests++;
            if (i == 3 && (bus.mRD !== 1'b1 || bus.mWR !== 1'b0 || bus.RegWre !== 1'b0)) begin
                $display("FAIL lw_mem got mRD=%b mWR=%b RegWre=%b exp 1,0,0", bus.mRD, bus.mWR, bus.RegWre); n_fail++;
            end
            if (i == 3) n_tests++;
            if (i == 4 && (bus.DBDataSrc !== 1'b1 || bus.RegDst !== 2'd1 || bus.RegWre !== 1'b1 ||
                           bus.mRD !== 1'b1 || bus.WrRegDSrc !== 1'b1 || bus.PCSrc !== 2'd0)) begin
                $display("FAIL lw_wb got DBDataSrc=%b RegDst=%0d RegWre=%b mRD=%b WrRegDSrc=%b PCSrc=%0d exp 1,1,1,1,1,0",
                         bus.DBDataSrc, bus.RegDst, bus.RegWre, bus.mRD, bus.WrRegDSrc, bus.PCSrc); n_fail++;
            end
            if (i == 4) n_tests++;
            @(negedge CLK);
        end
        if (bus.state_o !== 4'b0000) begin $display("FAIL lw_return got=%b exp=0000", bus.state_o); n_fail++; end
        n_tests++;

        bus.op = 6'b110000;
        for (int i = 0; i < 4; i++) begin
            if (bus.state_o !== seq_sw[i]) begin $display("FAIL sw_state step=%0d got=%b exp=%b", i, bus.state_o, seq_sw[i]); n_fail++; end
            n_tests++;
            if (bus.RegWre !== 1'b0) begin $display("FAIL sw_regwre step=%0d got=%b exp=0", i, bus.RegWre); n_fail++; end
            n_tests++;
            if (i == 3 && (bus.mWR !== 1'b1 || bus.mRD !== 1'b0 || bus.PCWre !== 1'b1)) begin
                $display("FAIL sw_mem got mWR=%b mRD=%b PCWre=%b exp 1,0,1", bus.mWR, bus.mRD, bus.PCWre); n_fail++;
            end
            if (i == 3) n_tests++;
            @(negedge CLK);
        end
        if (bus.state_o !== 4'b0000) begin $display("FAIL sw_return got=%b exp=0000", bus.state_o); n_fail++; end
        n_tests++;
    endtask

    task automatic test_branch();
        logic [3:0] seq [3] = '{4'b0000, 4'b0001, 4'b0101};
        for (int z = 1; z >= 0; z--) begin
            bus.op   = 6'b110100;
            bus.zero = z[0];
            for (int i = 0; i < 3; i++) begin
                if (bus.state_o !== seq[i]) begin $display("FAIL beq_state zero=%0d step=%0d got=%b exp=%b", z, i, bus.state_o, seq[i]); n_fail++; end
                n_tests++;
                if (i == 2 && (bus.PCSrc !== (z ? 2'd1 : 2'd0) || bus.PCWre !== 1'b1 || bus.ALUOp !== 3'b001 || bus.ExtSel !== 1'b1)) begin
                    $display("FAIL beq_exe zero=%0d got PCSrc=%0d PCWre=%b ALUOp=%b ExtSel=%b exp %0d,1,001,1",
                             z, bus.PCSrc, bus.PCWre, bus.ALUOp, bus.ExtSel, z); n_fail++;
                end
                if (i == 2) n_tests++;
                @(negedge CLK);
            end
            if (bus.state_o !== 4'b0000) begin $display("FAIL beq_return zero=%0d got=%b exp=0000", z, bus.state_o); n_fail++; end
            n_tests++;
        end
        bus.zero = 1'b0;
    endtask

    // Two-cycle ops decided in ID: jal, jr, j, and an undefined opcode (nop).
    task automatic test_jumps();
        logic [5:0] t_op  [4] = '{6'b111010, 6'b111001, 6'b111000, 6'b000011};
        logic [1:0] t_src [4] = '{2'd3, 2'd2, 2'd3, 2'd0};
        logic       t_rw  [4] = '{1, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            bus.op = t_op[k];
            if (bus.state_o !== 4'b0000) begin $display("FAIL jmp_if op=%b got=%b exp=0000", t_op[k], bus.state_o); n_fail++; end
            n_tests++;
            @(negedge CLK);
            if (bus.state_o !== 4'b0001 || bus.PCWre !== 1'b1 || bus.PCSrc !== t_src[k] || bus.RegWre !== t_rw[k]) begin
                $display("FAIL jmp_id op=%b got state=%b PCWre=%b PCSrc=%0d RegWre=%b exp 0001,1,%0d,%b",
                         t_op[k], bus.state_o, bus.PCWre, bus.PCSrc, bus.RegWre, t_src[k], t_rw[k]); n_fail++;
            end
            n_tests++;
            if (k == 0 && (bus.RegDst !== 2'd0 || bus.WrRegDSrc !== 1'b0)) begin
                $display("FAIL jal_link got RegDst=%0d WrRegDSrc=%b exp 0,0", bus.RegDst, bus.WrRegDSrc); n_fail++;
            end
            if (k == 0) n_tests++;
            @(negedge CLK);
            if (bus.state_o !== 4'b0000) begin $display("FAIL jmp_return op=%b got=%b exp=0000", t_op[k], bus.state_o); n_fail++; end
            n_tests++;
        end
    endtask

    task automatic test_halt_and_reset();
        bus.op = 6'b111111;
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 20; i++) begin
            if (bus.state_o !== 4'b1111 || bus.PCWre !== 1'b0 || bus.IRWre !== 1'b0 || bus.InsMemRW !== 1'b0 ||
                bus.RegWre !== 1'b0 || bus.mWR !== 1'b0 || bus.mRD !== 1'b0) begin
                $display("FAIL halt_hold cyc=%0d got state=%b PCWre=%b IRWre=%b InsMemRW=%b RegWre=%b mWR=%b mRD=%b exp 1111 and all 0",
                         i, bus.state_o, bus.PCWre, bus.IRWre, bus.InsMemRW, bus.RegWre, bus.mWR, bus.mRD); n_fail++;
            end
            n_tests++;
            @(negedge CLK);
        end
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        if (bus.state_o !== 4'b0000) begin $display("FAIL halt_reset got=%b exp=0000", bus.state_o); n_fail++; end
        n_tests++;

        bus.op = 6'b110001;
        repeat (3) @(negedge CLK);
        if (bus.state_o !== 4'b0011 || bus.mRD !== 1'b1) begin
            $display("FAIL lw_mid_pre got state=%b mRD=%b exp 0011,1", bus.state_o, bus.mRD); n_fail++;
        end
        n_tests++;
        RST = 1'b0;
        @(negedge CLK);
        if (bus.state_o !== 4'b0000 || bus.mRD !== 1'b0) begin
            $display("FAIL lw_mid_reset got state=%b mRD=%b exp 0000,0", bus.state_o, bus.mRD); n_fail++;
        end
        n_tests++;
        RST = 1'b1;
        @(negedge CLK);
        if (bus.state_o !== 4'b0001) begin $display("FAIL post_reset_id got=%b exp=0001", bus.state_o); n_fail++; end
        n_tests++;
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_load_store();
        test_branch();
        test_jumps();
        test_halt_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
